// File: rtl/parity_mem_pkg.sv
// Shared defaults and the even-parity helper for the parity-protected memory.
package parity_mem_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned PAR_MAX_W  = 64;

    // Even parity over the low w bits; callers zero-extend narrower words.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d,
                                         input int unsigned          w);
        logic p;
        p = 1'b0;
        for (int unsigned i = 0; i < PAR_MAX_W; i++) begin
            if (i < w) p = p ^ d[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/parity_gen.sv
// Combinational even-parity generator for one data word.
module parity_gen
    import parity_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] data_i,
    output logic              parity_c_o
);

    assign parity_c_o = even_parity(PAR_MAX_W'(data_i), DATA_W);

endmodule

// File: rtl/parity_mem.sv
// Single-port memory storing {parity, data} with read-side parity checking,
// read/write collision detection and saturating error counters.
module parity_mem
    import parity_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic              read,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              inject_par,
    input  logic              clr_cnt,
    output logic [DATA_W:0]   data_out,
    output logic              rd_valid,
    output logic              par_err,
    output logic              coll_err,
    output logic [CNT_W-1:0]  par_err_count,
    output logic [CNT_W-1:0]  coll_err_count
);

    localparam int unsigned      DEPTH   = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W:0]    mem_q [DEPTH];
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [DATA_W:0]    data_out_q, data_out_d;
    logic               rd_valid_q, rd_valid_d;
    logic               par_err_q, par_err_d;
    logic               coll_err_q, coll_err_d;
    logic [CNT_W-1:0]   par_cnt_q, par_cnt_d;
    logic [CNT_W-1:0]   coll_cnt_q, coll_cnt_d;

    logic               wr_ok_c, rd_ok_c;
    logic               wr_par_c, rd_par_c;
    logic [DATA_W:0]    rd_word_c;

    assign wr_ok_c   = write & ~read;
    assign rd_ok_c   = read & ~write;
    assign rd_word_c = mem_q[address];

    parity_gen #(.DATA_W(DATA_W)) u_wr_par (
        .data_i     (data_in),
        .parity_c_o (wr_par_c)
    );

    parity_gen #(.DATA_W(DATA_W)) u_rd_par (
        .data_i     (rd_word_c[DATA_W-1:0]),
        .parity_c_o (rd_par_c)
    );

    // Next-state: read capture, error pulses, counters and valid bits
    always_comb begin
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
        par_err_d  = 1'b0;
        coll_err_d = write & read;
        par_cnt_d  = par_cnt_q;
        coll_cnt_d = coll_cnt_q;
        valid_d    = valid_q;

        if (rd_ok_c) begin
            rd_valid_d = 1'b1;
            data_out_d = valid_q[address] ? rd_word_c : '0;
            par_err_d  = valid_q[address] & (rd_par_c ^ rd_word_c[DATA_W]);
        end

        if (wr_ok_c) valid_d[address] = 1'b1;

        // Counters track the pulses registered at this same edge
        if (clr_cnt) begin
            par_cnt_d  = '0;
            coll_cnt_d = '0;
        end else begin
            if (par_err_d && par_cnt_q != CNT_MAX)   par_cnt_d  = par_cnt_q + CNT_W'(1);
            if (coll_err_d && coll_cnt_q != CNT_MAX) coll_cnt_d = coll_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            par_err_q  <= 1'b0;
            coll_err_q <= 1'b0;
            par_cnt_q  <= '0;
            coll_cnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
            par_err_q  <= par_err_d;
            coll_err_q <= coll_err_d;
            par_cnt_q  <= par_cnt_d;
            coll_cnt_q <= coll_cnt_d;
        end
    end

    // Data array has no reset; unwritten entries are masked by valid_q
    always_ff @(posedge clk) begin
        if (!reset && wr_ok_c) mem_q[address] <= {wr_par_c ^ inject_par, data_in};
    end

    assign data_out       = data_out_q;
    assign rd_valid       = rd_valid_q;
    assign par_err        = par_err_q;
    assign coll_err       = coll_err_q;
    assign par_err_count  = par_cnt_q;
    assign coll_err_count = coll_cnt_q;

endmodule
